sdram_burst_arbiter: RTL

Shares the single-command SDRAM burst controller (IDLE/WRITE/READ command, 25-bit address, 16-bit data) between NumPorts requesters, for example a weight loader and an activation writer. It grants requesters in round-robin order and issues exactly one burst command per grant. It sequences the write beats and steers returning read beats to the owning requester. A watchdog flags a controller that never responds.

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sdram_burst_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller command encoding, widths and arbiter states.
// Imported by the burst arbiter.
package sdram_pkg;

    localparam int SdramAddrWidth = 25;
    localparam int SdramDataWidth = 16;

    typedef enum logic [1:0] {
        SDRAM_IDLE  = 2'd0,
        SDRAM_WRITE = 2'd1,
        SDRAM_READ  = 2'd2
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_ACK,
        ARB_WRITE_BURST,
        ARB_READ_BURST,
        ARB_GAP
    } arb_state_e;

    // Saturating increment shared by the beat and watchdog counters.
    function automatic logic [31:0] increment_then_stop(
        input logic [31:0] value,
        input logic [31:0] limit
    );
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping around, as both one-hot and index.
module rr_arbiter #(
    parameter  int NumPorts = 2,
    localparam int IdxW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o
);

    always_comb begin
        logic [IdxW-1:0] p;
        p       = '0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            p = IdxW'((int'(ptr_i) + i) % NumPorts);
            if (!valid_o && req_i[p]) begin
                valid_o  = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = p;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Round-robin sharing of one single-command SDRAM burst controller between
// several requesters, with beat sequencing, read steering and a watchdog.
module sdram_burst_arbiter
    import sdram_pkg::*;
#(
    parameter int NumPorts      = 2,
    parameter int BurstLength   = 8,
    parameter int WriteBurst    = 1,
    parameter int TimeoutCycles = 64
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumPorts-1:0]                     req_i,
    input  logic [NumPorts-1:0]                     we_i,
    input  logic [NumPorts-1:0][SdramAddrWidth-1:0] addr_i,
    input  logic [NumPorts-1:0][SdramDataWidth-1:0] wdata_i,
    output logic [NumPorts-1:0]                     gnt_o,
    output logic [NumPorts-1:0]                     wdata_ready_o,
    output logic [SdramDataWidth-1:0]               rdata_o,
    output logic [NumPorts-1:0]                     rdata_valid_o,
    output logic                                    busy_o,
    output logic                                    timeout_o,
    output logic [1:0]                              sdram_command_o,
    output logic [SdramAddrWidth-1:0]               sdram_address_o,
    output logic [SdramDataWidth-1:0]               sdram_write_data_o,
    input  logic [SdramDataWidth-1:0]               sdram_read_data_i,
    input  logic                                    sdram_read_valid_i,
    input  logic                                    sdram_write_done_i
);

    localparam int IdxW  = $clog2(NumPorts);
    localparam int BeatW = $clog2(BurstLength + 1);
    localparam int WdogW = $clog2(TimeoutCycles + 1);
    localparam bit MultiWrite = (WriteBurst != 0) && (BurstLength > 1);
    localparam logic [BeatW-1:0] LastBeat  = BeatW'(BurstLength - 1);
    localparam logic [WdogW-1:0] WdogLimit = WdogW'(TimeoutCycles);

    arb_state_e                state_q, state_d;
    logic [IdxW-1:0]           rr_q, rr_d;
    logic [IdxW-1:0]           owner_q, owner_d;
    logic                      we_q, we_d;
    logic [SdramAddrWidth-1:0] addr_q, addr_d;
    logic [BeatW-1:0]          beat_q, beat_d, beat_inc;
    logic [WdogW-1:0]          wdog_q, wdog_d, wdog_inc;
    logic                      timeout_q, timeout_d;
    logic [SdramDataWidth-1:0] rdata_q, rdata_d;
    logic [NumPorts-1:0]       rdata_valid_q, rdata_valid_d;

    logic [NumPorts-1:0] arb_oh;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_valid;
    logic [NumPorts-1:0] owner_oh;
    sdram_cmd_e          cmd;

    rr_arbiter #(.NumPorts(NumPorts)) u_rr (
        .req_i  (req_i),
        .ptr_i  (rr_q),
        .gnt_o  (arb_oh),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    assign owner_oh = NumPorts'(1) << owner_q;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        wdog_d        = wdog_q;
        timeout_d     = timeout_q;
        rdata_d       = '0;
        rdata_valid_d = '0;
        gnt_o         = '0;
        wdata_ready_o = '0;
        cmd           = SDRAM_IDLE;
        beat_inc = BeatW'(increment_then_stop(32'(beat_q), 32'(BurstLength)));
        wdog_inc = WdogW'(increment_then_stop(32'(wdog_q), 32'(TimeoutCycles)));
        unique case (state_q)
            ARB_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    we_d    = |(we_i & arb_oh);
                    addr_d  = addr_i[arb_idx];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cmd     = we_q ? SDRAM_WRITE : SDRAM_READ;
                gnt_o   = owner_oh;
                rr_d    = (owner_q == IdxW'(NumPorts - 1)) ? '0 : owner_q + 1'b1;
                beat_d  = '0;
                wdog_d  = '0;
                state_d = ARB_WAIT_ACK;
            end
            ARB_WAIT_ACK: begin
                wdog_d = wdog_inc;
                if (we_q && sdram_write_done_i) begin
                    wdata_ready_o = owner_oh;
                    beat_d        = BeatW'(1);
                    state_d       = MultiWrite ? ARB_WRITE_BURST : ARB_GAP;
                end else if (!we_q && sdram_read_valid_i) begin
                    rdata_d       = sdram_read_data_i;
                    rdata_valid_d = owner_oh;
                    beat_d        = BeatW'(1);
                    wdog_d        = '0;
                    state_d       = (BurstLength == 1) ? ARB_GAP : ARB_READ_BURST;
                end else if (wdog_inc == WdogLimit) begin
                    timeout_d = 1'b1;
                    state_d   = ARB_GAP;
                end
            end
            ARB_WRITE_BURST: begin
                wdata_ready_o = owner_oh;
                beat_d        = beat_inc;
                if (beat_q == LastBeat) state_d = ARB_GAP;
            end
            ARB_READ_BURST: begin
                // Stalls in the read stream are not beats but do feed the watchdog.
                if (sdram_read_valid_i) begin
                    rdata_d       = sdram_read_data_i;
                    rdata_valid_d = owner_oh;
                    beat_d        = beat_inc;
                    wdog_d        = '0;
                    if (beat_q == LastBeat) state_d = ARB_GAP;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WdogLimit) begin
                        timeout_d = 1'b1;
                        state_d   = ARB_GAP;
                    end
                end
            end
            ARB_GAP: state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARB_IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            beat_q        <= '0;
            wdog_q        <= '0;
            timeout_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            beat_q        <= beat_d;
            wdog_q        <= wdog_d;
            timeout_q     <= timeout_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign busy_o          = (state_q != ARB_IDLE);
    assign timeout_o       = timeout_q;
    assign rdata_o         = rdata_q;
    assign rdata_valid_o   = rdata_valid_q;
    assign sdram_command_o = cmd;
    assign sdram_address_o = (state_q == ARB_ISSUE) ? addr_q : '0;
    assign sdram_write_data_o =
        (state_q == ARB_ISSUE || state_q == ARB_WAIT_ACK ||
         state_q == ARB_WRITE_BURST) ? wdata_i[owner_q] : '0;

endmodule
